rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
Write-port controller for the 32x32 integer register file (single write port, x0 hardwired to zero). Shares the one write port between the in-order pipeline writeback stage and a long-latency unit (load/mul/div return path). Keeps a 32-bit pending scoreboard of destinations owned by the long-latency unit, which drives hazard detection. Registered write outputs connect directly to the register file's write-enable, rd and data inputs.

Parameters:
XLEN, 32, data width.
STARVE_LIMIT, 4, max consecutive cycles the long-latency unit may be blocked before the pipeline is stalled; legal 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active-high.
wb_valid  in  1  pipeline writeback request; held stable while pipe_stall=1.
wb_rd  in  5  pipeline destination.
wb_data  in  XLEN  pipeline result.
lu_valid  in  1  long-latency result valid; held until lu_ready.
lu_rd  in  5  long-latency destination.
lu_data  in  XLEN  long-latency result.
lu_ready  out  1  long-latency result accepted this cycle (when lu_valid=1).
iss_valid  in  1  long-latency op issued, will write iss_rd.
iss_rd  in  5  destination of issued op.
iss_conflict  out  1  issue rejected; iss_rd already pending. Issuer must retry.
rs1  in  5  decode source 1.
rs2  in  5  decode source 2.
rs1_busy  out  1  rs1 value not yet in register file.
rs2_busy  out  1  rs2 value not yet in register file.
pipe_stall  out  1  freeze the pipeline; writeback not accepted this cycle.
rf_en  out  1  register file write enable (registered).
rf_rd  out  5  register file write address (registered).
rf_data  out  XLEN  register file write data (registered).
pending  out  32  scoreboard bits (debug/hazard use).

Behaviour:
- Reset (rst=1 at an edge): state=NORMAL, starve counter=0, pending=0, rf_en=0, rf_rd=0, rf_data=0, commit flag=0. Reset takes priority over all events, including mid-FORCE or mid-commit.
- FSM states: NORMAL and FORCE.
  - NORMAL: pipe_stall=0. lu_ready=!wb_valid (writeback has priority).
  - FORCE: pipe_stall=1. lu_ready=1. wb_valid is ignored.
- Starve counter:
  - Increments each NORMAL cycle with lu_valid=1 and lu_ready=0.
  - Clears on an lu handshake or when lu_valid=0.
  - NORMAL->FORCE when the counter equals STARVE_LIMIT-1 and the unit is still blocked; FORCE begins on the next cycle.
- FORCE->NORMAL on the lu handshake, or if lu_valid drops (protocol violation, no write). The counter clears on exit.
- Winner per cycle:
  - lu, if the lu handshake occurs.
  - Otherwise wb, if NORMAL and wb_valid.
  - Otherwise none.
- Write timing: at the next edge rf_en <= winner_valid && winner_rd!=0, and rf_rd/rf_data <= winner's fields. Latency is 1 cycle request->rf_en; the register file latches at the end of the rf_en cycle.
- When there is no winner, or rd=0: rf_en=0 and rf_rd/rf_data hold their previous values.
- Scoreboard set:
  - pending[iss_rd] <= 1 when iss_valid && !iss_conflict && iss_rd!=0.
  - iss_conflict = iss_valid && pending[iss_rd] (combinational). Issue with rd=0 is accepted and not recorded.
- Scoreboard clear:
  - A registered commit flag marks that the current rf_en came from lu.
  - pending[rf_rd] clears at the edge ending that rf_en cycle, i.e. when the data actually lands.
  - Busy therefore covers the in-flight cycle.
  - Same-rd clear and set cannot coincide, because issue checks the current bits.
- rs1_busy = pending[rs1], rs2_busy = pending[rs2]; x0 is never busy.
- WAW: a pipeline writeback to a pending rd is the hazard unit's job (use rs/rd busy); the arbiter writes it regardless.

Decomposition:
- Package rf_ctrl_pkg: state enum (NORMAL, FORCE), REG_ADDR_W=5, NUM_REGS=32, XLEN.
- Sub-module rf_scoreboard holds the 32-bit pending vector and its set/clear/conflict/busy logic.
- Arbiter FSM, starve counter and output registers stay in the top.

Test Plan:
- Reset: assert rst 2 cycles mid-traffic, then release. Expect rf_en=0, pending=0, pipe_stall=0, lu_ready=1 with wb_valid=0.
- WB path: wb_valid, rd=5, data=0xDEADBEEF. Next cycle expect rf_en=1, rf_rd=5, rf_data=0xDEADBEEF. Repeat with rd=0: rf_en stays 0.
- Starvation, STARVE_LIMIT=4: wb_valid held 1 continuously, lu_valid rd=7 data=0x12345678.
  - lu_ready=0 for 4 cycles.
  - Then pipe_stall=1 and lu_ready=1 for exactly 1 cycle.
  - Next cycle rf_en=1, rf_rd=7; the wb write follows on the cycle after.
- Scoreboard: iss rd=10.
  - Next cycle pending[10]=1; rs1=10 gives rs1_busy=1; re-issue rd=10 gives iss_conflict=1.
  - lu returns rd=10: busy stays 1 through the rf_en cycle and is 0 the cycle after.
- Idle arbitration: wb_valid=0, lu_valid rd=3. Expect lu_ready=1 the same cycle and rf_en rd=3 the next cycle.
- Reset in FORCE: rst during pipe_stall=1. Next cycle expect state NORMAL, pending=0, rf_en=0.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// Shared types and sizes for the register-file write-port controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    // NORMAL: writeback has priority; FORCE: long-latency unit owns the port
    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback, long-latency, issue, decode and register-file signals.
// Latency: n/a (wiring only).
// Backpressure: lu_ready / pipe_stall travel slave->master, requests master->slave.
interface rf_wb_arbiter_if #(
    parameter int XLEN = rf_ctrl_pkg::XLEN
);
    logic                                   wb_valid;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     wb_rd;
    logic [XLEN-1:0]                        wb_data;
    logic                                   lu_valid;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     lu_rd;
    logic [XLEN-1:0]                        lu_data;
    logic                                   lu_ready;
    logic                                   iss_valid;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     iss_rd;
    logic                                   iss_conflict;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     rs1;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     rs2;
    logic                                   rs1_busy;
    logic                                   rs2_busy;
    logic                                   pipe_stall;
    logic                                   rf_en;
    logic [rf_ctrl_pkg::REG_ADDR_W-1:0]     rf_rd;
    logic [XLEN-1:0]                        rf_data;
    logic [rf_ctrl_pkg::NUM_REGS-1:0]       pending;

    modport master (
        output wb_valid, wb_rd, wb_data,
        output lu_valid, lu_rd, lu_data,
        output iss_valid, iss_rd, rs1, rs2,
        input  lu_ready, iss_conflict, rs1_busy, rs2_busy, pipe_stall,
        input  rf_en, rf_rd, rf_data, pending
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data,
        input  lu_valid, lu_rd, lu_data,
        input  iss_valid, iss_rd, rs1, rs2,
        output lu_ready, iss_conflict, rs1_busy, rs2_busy, pipe_stall,
        output rf_en, rf_rd, rf_data, pending
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard for results owned by the long-latency unit.
// Latency: set/clear visible the cycle after the edge; conflict/busy are combinational.
// Backpressure: an issue to an already-pending rd is rejected via iss_conflict.
module rf_scoreboard
    import rf_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    iss_valid,
    input  logic [REG_ADDR_W-1:0]   iss_rd,
    input  logic                    clr_en,
    input  logic [REG_ADDR_W-1:0]   clr_rd,
    input  logic [REG_ADDR_W-1:0]   rs1,
    input  logic [REG_ADDR_W-1:0]   rs2,
    output logic                    iss_conflict,
    output logic                    rs1_busy,
    output logic                    rs2_busy,
    output logic [NUM_REGS-1:0]     pending
);

    logic [NUM_REGS-1:0] pend_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Conflict/busy lookups and one-hot set/clear masks; rd=0 is never recorded,
    // so x0 can never read as busy.
    always_comb begin
        iss_conflict = iss_valid && pend_q[iss_rd];
        rs1_busy     = pend_q[rs1];
        rs2_busy     = pend_q[rs2];
        set_mask     = '0;
        clr_mask     = '0;
        if (iss_valid && !iss_conflict && (iss_rd != '0)) begin
            set_mask[iss_rd] = 1'b1;
        end
        if (clr_en) begin
            clr_mask[clr_rd] = 1'b1;
        end
    end

    // Clear lands with the register-file write; a set for the same rd cannot
    // coincide because that issue would have seen the bit and conflicted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_mask) | set_mask;
        end
    end

    assign pending = pend_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the single register-file write port between pipeline writeback and the long-latency unit.
// Latency: 1 cycle from winning request to registered rf_en/rf_rd/rf_data.
// Backpressure: lu_ready withheld while writeback wins; after STARVE_LIMIT blocked cycles pipe_stall for one cycle.
module rf_wb_arbiter #(
    parameter int XLEN         = rf_ctrl_pkg::XLEN,
    parameter int STARVE_LIMIT = 4      // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    rf_wb_arbiter_if.slave   bus
);
    import rf_ctrl_pkg::arb_state_e;
    import rf_ctrl_pkg::NORMAL;
    import rf_ctrl_pkg::FORCE;
    import rf_ctrl_pkg::REG_ADDR_W;

    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    arb_state_e             state_q;
    logic [3:0]             starve_q;
    logic                   rf_en_q;
    logic [REG_ADDR_W-1:0]  rf_rd_q;
    logic [XLEN-1:0]        rf_data_q;
    logic                   commit_q;

    logic                   lu_ready;
    logic                   lu_hs;
    logic                   wb_win;
    logic                   win_vld;
    logic [REG_ADDR_W-1:0]  win_rd;
    logic [XLEN-1:0]        win_data;

    // Per-cycle winner: the long-latency handshake beats writeback, writeback
    // is ignored entirely while the pipeline is frozen.
    always_comb begin
        lu_ready = (state_q == FORCE) || !bus.wb_valid;
        lu_hs    = bus.lu_valid && lu_ready;
        wb_win   = (state_q == NORMAL) && bus.wb_valid && !lu_hs;
        win_vld  = lu_hs || wb_win;
        win_rd   = lu_hs ? bus.lu_rd   : bus.wb_rd;
        win_data = lu_hs ? bus.lu_data : bus.wb_data;
    end

    // Starvation FSM. FORCE always exits after one cycle: lu_ready is 1 there,
    // so either the handshake happens or lu_valid has dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= NORMAL;
            starve_q <= '0;
        end else begin
            case (state_q)
                NORMAL: begin
                    if (bus.lu_valid && !lu_ready) begin
                        if (starve_q == LIMIT_M1) begin
                            state_q  <= FORCE;
                            starve_q <= '0;
                        end else begin
                            starve_q <= starve_q + 4'd1;
                        end
                    end else begin
                        starve_q <= '0;
                    end
                end
                FORCE: begin
                    state_q  <= NORMAL;
                    starve_q <= '0;
                end
                default: begin
                    state_q  <= NORMAL;
                    starve_q <= '0;
                end
            endcase
        end
    end

    // Registered write port; address/data hold when nothing is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_en_q   <= 1'b0;
            rf_rd_q   <= '0;
            rf_data_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            rf_en_q  <= win_vld && (win_rd != '0);
            commit_q <= lu_hs && (bus.lu_rd != '0);
            if (win_vld && (win_rd != '0)) begin
                rf_rd_q   <= win_rd;
                rf_data_q <= win_data;
            end
        end
    end

    rf_scoreboard u_sb (
        .clk          (clk),
        .rst          (rst),
        .iss_valid    (bus.iss_valid),
        .iss_rd       (bus.iss_rd),
        .clr_en       (rf_en_q && commit_q),
        .clr_rd       (rf_rd_q),
        .rs1          (bus.rs1),
        .rs2          (bus.rs2),
        .iss_conflict (bus.iss_conflict),
        .rs1_busy     (bus.rs1_busy),
        .rs2_busy     (bus.rs2_busy),
        .pending      (bus.pending)
    );

    assign bus.lu_ready   = lu_ready;
    assign bus.pipe_stall = (state_q == FORCE);
    assign bus.rf_en      = rf_en_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_data    = rf_data_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed vectors, a behavioural model checked every cycle.
// Latency: model expects registered write one cycle after the winning request.
// Backpressure: stimulus holds lu/wb requests while the DUT withholds acceptance.
module tb_rf_wb_arbiter;

    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter_if #(.XLEN(32)) bus ();

    rf_wb_arbiter #(.XLEN(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_force: the long-latency unit is guaranteed the port this cycle.
    // m_blocked: how many consecutive cycles the unit has been refused.
    // m_land: rd whose long-latency data is being written this cycle (0 = none).
    bit          m_ok = 1'b0;
    bit          m_force;
    int          m_blocked;
    logic [31:0] m_pend;
    logic        m_en;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic [4:0]  m_land;
    logic        e_ready, taken, accept;

    always @(negedge clk) begin
        if (m_ok) begin
            chk("lu_ready",   32'(bus.lu_ready),     32'(m_force || !bus.wb_valid));
            chk("pipe_stall", 32'(bus.pipe_stall),   32'(m_force));
            chk("conflict",   32'(bus.iss_conflict), 32'(bus.iss_valid && m_pend[bus.iss_rd]));
            chk("rs1_busy",   32'(bus.rs1_busy),     32'(m_pend[bus.rs1]));
            chk("rs2_busy",   32'(bus.rs2_busy),     32'(m_pend[bus.rs2]));
            chk("pending",    bus.pending,           m_pend);
            chk("rf_en",      32'(bus.rf_en),        32'(m_en));
            chk("rf_rd",      32'(bus.rf_rd),        32'(m_rd));
            chk("rf_data",    bus.rf_data,           m_data);
        end
        if (rst) begin
            m_force = 0; m_blocked = 0; m_pend = '0;
            m_en = 0; m_rd = '0; m_data = '0; m_land = '0; m_ok = 1'b1;
        end else if (m_ok) begin
            e_ready = m_force || !bus.wb_valid;
            taken   = bus.lu_valid && e_ready;
            accept  = bus.iss_valid && !m_pend[bus.iss_rd] && (bus.iss_rd != 0);
            if (m_land != 0) m_pend[m_land] = 1'b0;
            if (accept) m_pend[bus.iss_rd] = 1'b1;
            m_en = 1'b0;
            if (taken && bus.lu_rd != 0) begin
                m_en = 1'b1; m_rd = bus.lu_rd; m_data = bus.lu_data;
            end else if (!taken && !m_force && bus.wb_valid && bus.wb_rd != 0) begin
                m_en = 1'b1; m_rd = bus.wb_rd; m_data = bus.wb_data;
            end
            m_land = taken ? bus.lu_rd : 5'd0;
            if (m_force) begin
                m_force = 0; m_blocked = 0;
            end else if (bus.lu_valid && !e_ready) begin
                m_blocked++;
                if (m_blocked == LIMIT) begin
                    m_force = 1; m_blocked = 0;
                end
            end else begin
                m_blocked = 0;
            end
        end
    end

    // Protocol bookkeeping for the stimulus: what was accepted at the last edge.
    logic lu_took = 1'b0;
    logic wb_held = 1'b0;
    always @(posedge clk) begin
        lu_took <= bus.lu_valid && bus.lu_ready;
        wb_held <= bus.wb_valid && bus.pipe_stall;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wb_valid = 0; bus.wb_rd = '0; bus.wb_data = '0;
        bus.lu_valid = 0; bus.lu_rd = '0; bus.lu_data = '0;
        bus.iss_valid = 0; bus.iss_rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    endtask

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        #1;
        // reset state
        chk("rst_rf_en",    32'(bus.rf_en), 32'd0);
        chk("rst_pending",  bus.pending, 32'd0);
        chk("rst_stall",    32'(bus.pipe_stall), 32'd0);
        chk("rst_lu_ready", 32'(bus.lu_ready), 32'd1);

        // writeback path
        bus.wb_valid = 1; bus.wb_rd = 5'd5; bus.wb_data = 32'hDEADBEEF;
        step();
        bus.wb_valid = 0; #1;
        chk("wb_en",   32'(bus.rf_en), 32'd1);
        chk("wb_rd",   32'(bus.rf_rd), 32'd5);
        chk("wb_data", bus.rf_data, 32'hDEADBEEF);
        bus.wb_valid = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h11111111;
        step();
        bus.wb_valid = 0; #1;
        chk("wb_x0_en",   32'(bus.rf_en), 32'd0);
        chk("wb_x0_hold", bus.rf_data, 32'hDEADBEEF);

        // starvation
        bus.wb_valid = 1; bus.wb_rd = 5'd6; bus.wb_data = 32'hAAAA0006;
        bus.lu_valid = 1; bus.lu_rd = 5'd7; bus.lu_data = 32'h12345678;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("starve_ready", 32'(bus.lu_ready), 32'd0);
            chk("starve_stall", 32'(bus.pipe_stall), 32'd0);
            step();
        end
        #1;
        chk("force_stall", 32'(bus.pipe_stall), 32'd1);
        chk("force_ready", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 0; #1;
        chk("force_wr_en",   32'(bus.rf_en), 32'd1);
        chk("force_wr_rd",   32'(bus.rf_rd), 32'd7);
        chk("force_wr_data", bus.rf_data, 32'h12345678);
        chk("force_exit",    32'(bus.pipe_stall), 32'd0);
        step();
        bus.wb_valid = 0; #1;
        chk("after_force_rd", 32'(bus.rf_rd), 32'd6);
        chk("after_force_en", 32'(bus.rf_en), 32'd1);

        // scoreboard
        bus.iss_valid = 1; bus.iss_rd = 5'd10;
        step();
        bus.iss_valid = 0; bus.rs1 = 5'd10; bus.rs2 = 5'd10; #1;
        chk("sb_pending", bus.pending, 32'h0000_0400);
        chk("sb_rs1",     32'(bus.rs1_busy), 32'd1);
        chk("sb_rs2",     32'(bus.rs2_busy), 32'd1);
        bus.iss_valid = 1; bus.iss_rd = 5'd0; #1;
        chk("sb_x0_noconf", 32'(bus.iss_conflict), 32'd0);
        bus.iss_rd = 5'd10; #1;
        chk("sb_conflict", 32'(bus.iss_conflict), 32'd1);
        step();
        bus.iss_valid = 0;
        bus.lu_valid = 1; bus.lu_rd = 5'd10; bus.lu_data = 32'hCAFE000A; #1;
        chk("sb_lu_ready", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 0; #1;
        chk("sb_inflight_en",   32'(bus.rf_en), 32'd1);
        chk("sb_inflight_rd",   32'(bus.rf_rd), 32'd10);
        chk("sb_inflight_busy", 32'(bus.rs1_busy), 32'd1);
        step(); #1;
        chk("sb_cleared_busy", 32'(bus.rs1_busy), 32'd0);
        chk("sb_cleared_pend", bus.pending, 32'd0);

        // idle arbitration
        bus.lu_valid = 1; bus.lu_rd = 5'd3; bus.lu_data = 32'h00000333; #1;
        chk("idle_ready", 32'(bus.lu_ready), 32'd1);
        step();
        bus.lu_valid = 0; #1;
        chk("idle_en", 32'(bus.rf_en), 32'd1);
        chk("idle_rd", 32'(bus.rf_rd), 32'd3);

        // reset while in FORCE
        bus.iss_valid = 1; bus.iss_rd = 5'd12;
        step();
        bus.iss_valid = 0;
        bus.wb_valid = 1; bus.wb_rd = 5'd9; bus.wb_data = 32'h99999999;
        bus.lu_valid = 1; bus.lu_rd = 5'd12; bus.lu_data = 32'hC0C0C0C0;
        for (int k = 0; k < 4; k++) step();
        #1;
        chk("rf_force_stall", 32'(bus.pipe_stall), 32'd1);
        rst = 1;
        step(); #1;
        chk("rf_rst_stall",   32'(bus.pipe_stall), 32'd0);
        chk("rf_rst_pending", bus.pending, 32'd0);
        chk("rf_rst_en",      32'(bus.rf_en), 32'd0);
        step();
        rst = 0;

        // mixed traffic honouring the hold rules, checked by the model
        for (int i = 0; i < 80; i++) begin
            step();
            if (!(bus.lu_valid && !lu_took)) begin
                bus.lu_valid = (i % 3 != 0);
                bus.lu_rd    = 5'((i * 7) % 32);
                bus.lu_data  = 32'(i) * 32'h01010101;
            end
            if (!wb_held) begin
                bus.wb_valid = (i % 4 != 1);
                bus.wb_rd    = 5'((i * 5) % 32);
                bus.wb_data  = 32'hB0000000 + 32'(i);
            end
            bus.iss_valid = (i % 5 == 2);
            bus.iss_rd    = 5'((i * 3) % 32);
            bus.rs1       = 5'((i * 11) % 32);
            bus.rs2       = 5'((i * 13) % 32);
        end
        step();
        idle();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
